// File: rtl/gba_sound_pkg.sv
// Shared types for the sound channels: wave-channel volume codes,
// the playback sequencer states and the wave-RAM bank geometry.
package gba_sound_pkg;

    typedef enum logic [1:0] {
        VOL_MUTE,
        VOL_100,
        VOL_50,
        VOL_25
    } wave_vol_t;

    typedef enum logic {
        IDLE,
        PLAYING
    } wave_seq_state_t;

    localparam int WAVE_BANK_BITS = 128;

endpackage

// File: rtl/wave_volume_scaler.sv
// Channel-3 output volume stage. Purely combinational so that a volume
// register write is heard immediately, without waiting for a sample tick.
// The 75% setting overrides the 2-bit volume code.
module wave_volume_scaler
    import gba_sound_pkg::*;
#(
    parameter int SAMPLE_W = 4
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [1:0]          volume_code_i,
    input  logic                force_75_i,
    output logic [SAMPLE_W-1:0] wave_out_o
);

    logic [SAMPLE_W+1:0] tripleSample;

    // s*3 built as s + 2s in a two-bit-wider word so the 75% path never overflows
    assign tripleSample = {2'b00, sample_i} + {1'b0, sample_i, 1'b0};

    // Select the attenuated sample; 75% wins over whatever the code says
    always_comb begin
        wave_out_o = '0;
        if (force_75_i) begin
            wave_out_o = tripleSample[SAMPLE_W+1:2];
        end else begin
            case (wave_vol_t'(volume_code_i))
                VOL_MUTE: wave_out_o = '0;
                VOL_100:  wave_out_o = sample_i;
                VOL_50:   wave_out_o = sample_i >> 1;
                VOL_25:   wave_out_o = sample_i >> 2;
                default:  wave_out_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/wave_sample_sequencer.sv
// Playback core of the wave channel. Each frequency-timer tick fetches the
// next 4-bit sample from the active wave-RAM bank, advances the position
// and, at the end of a bank, either flips to the other bank (64-sample
// mode) or reloads the selected bank (32-sample mode). A rising trigger
// restarts playback from sample 0; dropping play_enable parks the channel.
module wave_sample_sequencer
    import gba_sound_pkg::*;
#(
    parameter int SAMPLES_PER_BANK = 32,
    parameter int SAMPLE_W         = 4
) (
    input  logic                          frequency_timer_clock,
    input  logic                          reset,
    input  logic                          play_enable,
    input  logic                          dimension,
    input  logic                          bank_select,
    input  logic [1:0]                    volume_code,
    input  logic                          force_75,
    input  logic                          trigger,
    input  logic [2*WAVE_BANK_BITS-1:0]   wave_ram,
    output logic [SAMPLE_W-1:0]           wave_out,
    output logic [SAMPLE_W-1:0]           raw_sample,
    output logic [$clog2(SAMPLES_PER_BANK)-1:0] position,
    output logic                          current_bank,
    output logic                          channel_active
);

    localparam int POS_W = $clog2(SAMPLES_PER_BANK);
    localparam int RAM_W = 2 * WAVE_BANK_BITS;
    localparam int OFF_W = $clog2(RAM_W);

    wave_seq_state_t     state_q, state_d;
    logic [POS_W-1:0]    position_q, position_d;
    logic                bank_q, bank_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                trig_q;

    logic                trigRise;
    logic [POS_W:0]      nibbleIdx;
    logic [OFF_W-1:0]    bitOffset;
    logic [SAMPLE_W-1:0] fetchedSample;

    assign trigRise = trigger & ~trig_q;

    // Within a byte the even sample sits in the high nibble, so flipping the
    // low index bit turns sample order into nibble order in the flat RAM word
    assign nibbleIdx     = {bank_q, position_q ^ POS_W'(1)};
    assign bitOffset     = OFF_W'(nibbleIdx) * OFF_W'(SAMPLE_W);
    assign fetchedSample = wave_ram[bitOffset +: SAMPLE_W];

    // Next-state decode: disable beats trigger, trigger beats normal stepping
    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        bank_d     = bank_q;
        sample_d   = sample_q;
        if (!play_enable) begin
            state_d  = IDLE;
            sample_d = '0;
        end else if (trigRise) begin
            state_d    = PLAYING;
            position_d = '0;
            bank_d     = bank_select;
            sample_d   = '0;
        end else if (state_q == PLAYING) begin
            sample_d   = fetchedSample;
            position_d = position_q + POS_W'(1);
            if (position_q == '1) begin
                bank_d = dimension ? ~bank_q : bank_select;
            end
        end
    end

    // Sequencer registers; the trigger history updates every tick so that a
    // trigger edge arriving while disabled is consumed rather than deferred
    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            position_q <= '0;
            bank_q     <= 1'b0;
            sample_q   <= '0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            bank_q     <= bank_d;
            sample_q   <= sample_d;
            trig_q     <= trigger;
        end
    end

    wave_volume_scaler #(
        .SAMPLE_W (SAMPLE_W)
    ) uScaler (
        .sample_i      (sample_q),
        .volume_code_i (volume_code),
        .force_75_i    (force_75),
        .wave_out_o    (wave_out)
    );

    assign raw_sample     = sample_q;
    assign position       = position_q;
    assign current_bank   = bank_q;
    assign channel_active = (state_q == PLAYING);

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Directed bench for the wave-channel sequencer: reset behaviour, 32- and
// 64-sample playback, volume scaling, retrigger/disable and async reset.
module tb_wave_sample_sequencer;

    logic         frequency_timer_clock;
    logic         reset;
    logic         play_enable;
    logic         dimension;
    logic         bank_select;
    logic [1:0]   volume_code;
    logic         force_75;
    logic         trigger;
    logic [255:0] wave_ram;
    logic [3:0]   wave_out;
    logic [3:0]   raw_sample;
    logic [4:0]   position;
    logic         current_bank;
    logic         channel_active;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        string      name;
        logic [1:0] vol;
        logic       f75;
        logic [3:0] expOut;
    } volVec_t;

    volVec_t volTable[6];

    wave_sample_sequencer dut (
        .frequency_timer_clock (frequency_timer_clock),
        .reset                 (reset),
        .play_enable           (play_enable),
        .dimension             (dimension),
        .bank_select           (bank_select),
        .volume_code           (volume_code),
        .force_75              (force_75),
        .trigger               (trigger),
        .wave_ram              (wave_ram),
        .wave_out              (wave_out),
        .raw_sample            (raw_sample),
        .position              (position),
        .current_bank          (current_bank),
        .channel_active        (channel_active)
    );

    // Free-running sample-rate tick, rising edges at 5, 15, 25, ...
    initial begin
        frequency_timer_clock = 1'b0;
        forever #5 frequency_timer_clock = ~frequency_timer_clock;
    end

    // Expected sample value from the test pattern: bank0 ramps up, bank1 down
    function automatic logic [3:0] expSample(input logic bank, input int n);
        int v;
        v = n % 16;
        return bank ? 4'(15 - v) : 4'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next rising edge and settle just after it
    task automatic applyStimulus();
        @(posedge frequency_timer_clock);
        #1;
    endtask

    task automatic triggerPlay(input logic bankSel, input logic dim);
        bank_select = bankSel;
        dimension   = dim;
        trigger     = 1'b1;
        applyStimulus();
        trigger     = 1'b0;
    endtask

    initial begin
        volTable[0] = '{"vol mute", 2'b00, 1'b0, 4'd0};
        volTable[1] = '{"vol 100",  2'b01, 1'b0, 4'd15};
        volTable[2] = '{"vol 50",   2'b10, 1'b0, 4'd7};
        volTable[3] = '{"vol 25",   2'b11, 1'b0, 4'd3};
        volTable[4] = '{"vol 75a",  2'b00, 1'b1, 4'd11};
        volTable[5] = '{"vol 75b",  2'b10, 1'b1, 4'd11};

        for (int k = 0; k < 16; k++) begin
            wave_ram[8*k +: 8]       = {expSample(1'b0, 2*k), expSample(1'b0, 2*k+1)};
            wave_ram[128 + 8*k +: 8] = {expSample(1'b1, 2*k), expSample(1'b1, 2*k+1)};
        end

        reset       = 1'b1;
        play_enable = 1'b0;
        dimension   = 1'b0;
        bank_select = 1'b0;
        volume_code = 2'b01;
        force_75    = 1'b0;
        trigger     = 1'b0;

        #12;
        checkOutput("rst active",   32'(channel_active), 32'd0);
        checkOutput("rst raw",      32'(raw_sample),     32'd0);
        checkOutput("rst wave_out", 32'(wave_out),       32'd0);
        checkOutput("rst position", 32'(position),       32'd0);
        checkOutput("rst bank",     32'(current_bank),   32'd0);

        @(negedge frequency_timer_clock);
        reset       = 1'b0;
        play_enable = 1'b1;

        $display("[TB] idle after reset");
        for (int e = 0; e < 10; e++) begin
            applyStimulus();
            checkOutput("idle active",   32'(channel_active), 32'd0);
            checkOutput("idle wave_out", 32'(wave_out),       32'd0);
        end

        $display("[TB] 32-sample play from bank 0");
        triggerPlay(1'b0, 1'b0);
        checkOutput("trig active",   32'(channel_active), 32'd1);
        checkOutput("trig position", 32'(position),       32'd0);
        checkOutput("trig raw",      32'(raw_sample),     32'd0);
        for (int e = 1; e <= 32; e++) begin
            applyStimulus();
            checkOutput("p32 raw",      32'(raw_sample),   32'(expSample(1'b0, e - 1)));
            checkOutput("p32 wave_out", 32'(wave_out),     32'(expSample(1'b0, e - 1)));
            checkOutput("p32 position", 32'(position),     32'(e % 32));
            checkOutput("p32 bank",     32'(current_bank), 32'd0);
        end

        $display("[TB] 64-sample play across both banks");
        triggerPlay(1'b0, 1'b1);
        for (int e = 1; e <= 64; e++) begin
            logic expBank;
            logic srcBank;
            srcBank = (e > 32);
            expBank = (e >= 32 && e < 64);
            applyStimulus();
            checkOutput("p64 raw",  32'(raw_sample),   32'(expSample(srcBank, (e - 1) % 32)));
            checkOutput("p64 bank", 32'(current_bank), 32'(expBank));
        end

        $display("[TB] volume scaling on a full-scale sample");
        triggerPlay(1'b0, 1'b0);
        for (int e = 0; e < 16; e++) begin
            applyStimulus();
        end
        checkOutput("vol setup raw", 32'(raw_sample), 32'd15);
        for (int i = 0; i < 6; i++) begin
            volume_code = volTable[i].vol;
            force_75    = volTable[i].f75;
            #1;
            checkOutput(volTable[i].name, 32'(wave_out), 32'(volTable[i].expOut));
        end
        volume_code = 2'b01;
        force_75    = 1'b0;

        $display("[TB] retrigger, disable and held trigger");
        triggerPlay(1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            applyStimulus();
        end
        checkOutput("pre-retrig position", 32'(position), 32'd10);
        trigger = 1'b1;
        applyStimulus();
        checkOutput("retrig raw",      32'(raw_sample), 32'd0);
        checkOutput("retrig position", 32'(position),   32'd0);
        applyStimulus();
        checkOutput("held trig position", 32'(position), 32'd1);
        play_enable = 1'b0;
        applyStimulus();
        checkOutput("disable active",   32'(channel_active), 32'd0);
        checkOutput("disable wave_out", 32'(wave_out),       32'd0);
        checkOutput("disable position", 32'(position),       32'd1);
        play_enable = 1'b1;
        applyStimulus();
        checkOutput("reenable no restart", 32'(channel_active), 32'd0);
        applyStimulus();
        checkOutput("reenable still idle", 32'(channel_active), 32'd0);
        checkOutput("reenable position",   32'(position),       32'd1);
        trigger = 1'b0;
        applyStimulus();

        $display("[TB] asynchronous reset mid-play");
        triggerPlay(1'b1, 1'b0);
        for (int e = 0; e < 20; e++) begin
            applyStimulus();
        end
        checkOutput("pre-reset position", 32'(position),   32'd20);
        checkOutput("pre-reset raw",      32'(raw_sample), 32'(expSample(1'b1, 19)));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async raw",      32'(raw_sample),     32'd0);
        checkOutput("async wave_out", 32'(wave_out),       32'd0);
        checkOutput("async active",   32'(channel_active), 32'd0);
        checkOutput("async position", 32'(position),       32'd0);
        checkOutput("async bank",     32'(current_bank),   32'd0);
        #1;
        reset = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("post-reset idle", 32'(channel_active), 32'd0);
        triggerPlay(1'b1, 1'b0);
        checkOutput("resume active", 32'(channel_active), 32'd1);
        applyStimulus();
        checkOutput("resume raw",    32'(raw_sample),     32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
